// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory arbiter.
//   owner_e     : which requester owns the in-flight transaction
//   arb_state_e : arbiter FSM states
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IFU  = 2'd1,
      OWN_LSU  = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between IFU and LSU.
//   ifu_valid_i  : IFU request valid
//   lsu_valid_i  : LSU request valid
//   last_grant_i : requester granted most recently (tie-break input)
//   winner_o     : OWN_NONE, OWN_IFU or OWN_LSU
// On a tie the requester that was not granted last wins. Tying last_grant_i
// to OWN_IFU therefore yields fixed LSU-over-IFU priority.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic   ifu_valid_i,
   input  logic   lsu_valid_i,
   input  owner_e last_grant_i,
   output owner_e winner_o
);

   always_comb begin
      winner_o = OWN_NONE;
      if (ifu_valid_i && lsu_valid_i) begin
         winner_o = (last_grant_i == OWN_LSU) ? OWN_IFU : OWN_LSU;
      end else if (lsu_valid_i) begin
         winner_o = OWN_LSU;
      end else if (ifu_valid_i) begin
         winner_o = OWN_IFU;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch
// (IFU) and load/store (LSU), one transaction outstanding at a time.
//   clk, rst                 : clock, synchronous active-high reset
//   ifu_req_* / ifu_addr     : fetch request channel (valid/ready)
//   ifu_resp_valid/ifu_rdata : fetch response, one-cycle pulse
//   lsu_req_* / lsu_*        : load/store request channel (valid/ready)
//   lsu_resp_valid/lsu_rdata : load data / store completion, one-cycle pulse
//   mem_req_* / mem_*        : latched request towards the memory
//   mem_resp_valid/mem_rdata : memory response
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// ties; otherwise LSU has fixed priority over IFU.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   arb_state_e            state_q;
   owner_e                owner_q;
   logic                  mem_req_valid_q;
   logic [ADDR_W-1:0]     mem_addr_q;
   logic                  mem_wen_q;
   logic [DATA_W-1:0]     mem_wdata_q;
   logic [DATA_W/8-1:0]   mem_wmask_q;
   logic                  ifu_resp_valid_q;
   logic [DATA_W-1:0]     ifu_rdata_q;
   logic                  lsu_resp_valid_q;
   logic [DATA_W-1:0]     lsu_rdata_q;

   owner_e                winner;
   owner_e                last_grant;
   logic                  ifu_grant;
   logic                  lsu_grant;

   // Winner select; only meaningful while idle.
   arb_pick u_arb_pick (
      .ifu_valid_i  (ifu_req_valid),
      .lsu_valid_i  (lsu_req_valid),
      .last_grant_i (last_grant),
      .winner_o     (winner)
   );

   assign ifu_req_ready = (state_q == ARB_IDLE) && (winner == OWN_IFU);
   assign lsu_req_ready = (state_q == ARB_IDLE) && (winner == OWN_LSU);
   assign ifu_grant     = ifu_req_valid && ifu_req_ready;
   assign lsu_grant     = lsu_req_valid && lsu_req_ready;

`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_grant_q;

   // Remember the most recent grant so ties alternate.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= OWN_IFU;
      end else if (lsu_grant) begin
         last_grant_q <= OWN_LSU;
      end else if (ifu_grant) begin
         last_grant_q <= OWN_IFU;
      end
   end

   assign last_grant = last_grant_q;
`else
   // Constant IFU makes every tie resolve to LSU.
   assign last_grant = OWN_IFU;
`endif

   // Arbiter FSM with latched request fields and registered responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ARB_IDLE;
         owner_q          <= OWN_NONE;
         mem_req_valid_q  <= 1'b0;
         mem_addr_q       <= '0;
         mem_wen_q        <= 1'b0;
         mem_wdata_q      <= '0;
         mem_wmask_q      <= '0;
         ifu_resp_valid_q <= 1'b0;
         ifu_rdata_q      <= '0;
         lsu_resp_valid_q <= 1'b0;
         lsu_rdata_q      <= '0;
      end else begin
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (lsu_grant) begin
                  owner_q         <= OWN_LSU;
                  mem_addr_q      <= lsu_addr;
                  mem_wen_q       <= lsu_wen;
                  mem_wdata_q     <= lsu_wdata;
                  mem_wmask_q     <= lsu_wmask;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= ARB_REQ;
               end else if (ifu_grant) begin
                  owner_q         <= OWN_IFU;
                  mem_addr_q      <= ifu_addr;
                  mem_wen_q       <= 1'b0;
                  mem_wdata_q     <= '0;
                  mem_wmask_q     <= '0;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= ARB_REQ;
               end
            end
            ARB_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (mem_resp_valid) begin
                  if (owner_q == OWN_IFU) begin
                     ifu_rdata_q      <= mem_rdata;
                     ifu_resp_valid_q <= 1'b1;
                  end else if (owner_q == OWN_LSU) begin
                     lsu_rdata_q      <= mem_rdata;
                     lsu_resp_valid_q <= 1'b1;
                  end
                  owner_q <= OWN_NONE;
                  state_q <= ARB_IDLE;
               end
            end
            default: begin
               owner_q <= OWN_NONE;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign mem_req_valid  = mem_req_valid_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wen        = mem_wen_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_wmask      = mem_wmask_q;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign ifu_rdata      = ifu_rdata_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, response scoreboard,
// arbitration vector table and hand-written multi-cycle sequences.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [AW-1:0] ifu_addr;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic [MW-1:0] lsu_wmask;
   logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [MW-1:0] mem_wmask;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            lsu;
      bit            store;
      logic [DW-1:0] data;
   } exp_t;

   typedef struct {
      bit            iv;
      bit            lv;
      logic [AW-1:0] ia;
      logic [AW-1:0] la;
      bit            wen;
      logic [DW-1:0] wd;
      logic [MW-1:0] wm;
      int            stall;
      int            lat;
      int            exp_w;   // 0 none, 1 IFU, 2 LSU (fixed-priority result)
   } vec_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cfg_stall = 0;
   int            cfg_lat = 1;
   int            stall_cnt = 0;
   int            pend = 0;
   logic [DW-1:0] pend_data;
   bit            spurious = 1'b0;
   bit            model_last_lsu = 1'b0;

   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      if (a == 32'h8000_0000) return 32'h0010_0093;
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // Reference arbitration: LSU priority, or alternate on ties with round robin.
   function automatic int pick(input bit iv, input bit lv);
      if (iv && lv) begin
`ifdef ARB_ROUND_ROBIN_EN
         return model_last_lsu ? 1 : 2;
`else
         return 2;
`endif
      end
      if (lv) return 2;
      if (iv) return 1;
      return 0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory: ready after cfg_stall cycles, response cfg_lat cycles after handshake.
   always @(negedge clk) begin
      mem_resp_valid = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = pend_data;
         end
      end
      if (spurious) begin
         mem_resp_valid = 1'b1;
         mem_rdata      = 32'hBAD0_0BAD;
         spurious       = 1'b0;
      end
      if (mem_req_valid) begin
         if (stall_cnt < cfg_stall) begin
            mem_req_ready = 1'b0;
            stall_cnt++;
         end else begin
            mem_req_ready = 1'b1;
            stall_cnt     = 0;
            pend          = cfg_lat;
            pend_data     = mem_fn(mem_addr);
         end
      end else begin
         mem_req_ready = 1'b0;
      end
   end

   // Response monitor: pops the scoreboard on every response pulse.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (ifu_resp_valid || lsu_resp_valid) begin
         if (ifu_resp_valid && lsu_resp_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL dual_resp: ifu=1 lsu=1, expected one owner only");
         end else if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: ifu=%0b lsu=%0b, expected none", ifu_resp_valid, lsu_resp_valid);
         end else begin
            e = sb.pop_front();
            check("resp_owner_lsu", 64'(lsu_resp_valid), 64'(e.lsu));
            if (!e.store) check("resp_rdata", 64'(e.lsu ? lsu_rdata : ifu_rdata), 64'(e.data));
         end
      end
   end

   // Drive requesters, check readies, record the expected response.
   task automatic offer(input string tag, input bit iv, input bit lv, input logic [AW-1:0] ia,
                        input logic [AW-1:0] la, input bit wen, input logic [DW-1:0] wd,
                        input logic [MW-1:0] wm, input int w_exp, input bit track);
      exp_t e;
      ifu_req_valid = iv; lsu_req_valid = lv; ifu_addr = ia; lsu_addr = la;
      lsu_wen = wen; lsu_wdata = wd; lsu_wmask = wm;
      #1;
      check({tag, "_ifu_ready"}, 64'(ifu_req_ready), 64'(w_exp == 1));
      check({tag, "_lsu_ready"}, 64'(lsu_req_ready), 64'(w_exp == 2));
      if (w_exp != 0) begin
         model_last_lsu = (w_exp == 2);
         if (track) begin
            e.lsu = (w_exp == 2); e.store = (w_exp == 2) && wen;
            e.data = mem_fn((w_exp == 2) ? la : ia);
            sb.push_back(e);
         end
      end
   endtask

   task automatic check_mem(input string tag, input bit lsu, input logic [AW-1:0] a, input bit wen,
                            input logic [DW-1:0] wd, input logic [MW-1:0] wm);
      check({tag, "_mreq_valid"}, 64'(mem_req_valid), 64'(1));
      check({tag, "_maddr"}, 64'(mem_addr), 64'(a));
      check({tag, "_mwen"}, 64'(mem_wen), 64'(lsu && wen));
      check({tag, "_mwmask"}, 64'(mem_wmask), 64'(lsu ? wm : '0));
      if (lsu && wen) check({tag, "_mwdata"}, 64'(mem_wdata), 64'(wd));
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_drained"}, 64'(sb.size()), 64'(0));
      sb.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; model_last_lsu = 1'b0; sb.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_mreq_valid"}, 64'(mem_req_valid), 64'(0));
      check({tag, "_maddr"}, 64'(mem_addr), 64'(0));
      check({tag, "_mwdata"}, 64'(mem_wdata), 64'(0));
      check({tag, "_mwen_mask"}, 64'({mem_wen, mem_wmask}), 64'(0));
      check({tag, "_resp_valids"}, 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      check({tag, "_ifu_rdata"}, 64'(ifu_rdata), 64'(0));
      check({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[8];
      int   w_exp;
      int   rr_seq[4];

      vt[0] = '{1, 0, 32'h8000_0010, 32'h0,         0, 32'h0,         4'h0, 0, 1, 1};
      vt[1] = '{0, 1, 32'h0,         32'h8000_0100, 0, 32'h0,         4'h0, 0, 1, 2};
      vt[2] = '{1, 1, 32'h8000_0020, 32'h8000_0104, 0, 32'h0,         4'h0, 1, 2, 2};
      vt[3] = '{0, 1, 32'h0,         32'h8000_0200, 1, 32'hDEAD_BEEF, 4'hF, 2, 1, 2};
      vt[4] = '{1, 1, 32'h8000_0024, 32'h8000_0208, 1, 32'h1234_5678, 4'h3, 0, 3, 2};
      vt[5] = '{1, 0, 32'h8000_0004, 32'h0,         0, 32'h0,         4'h0, 2, 2, 1};
      vt[6] = '{0, 0, 32'h8000_0008, 32'h8000_0300, 0, 32'h0,         4'h0, 0, 1, 0};
      vt[7] = '{1, 1, 32'h8000_0028, 32'h8000_010C, 0, 32'h0,         4'h0, 1, 1, 2};
`ifdef ARB_ROUND_ROBIN_EN
      rr_seq = '{2, 1, 2, 1};
`else
      rr_seq = '{2, 2, 2, 2};
`endif

      ifu_req_valid = 0; lsu_req_valid = 0; ifu_addr = 0; lsu_addr = 0;
      lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      do_reset();
      check_outputs_zero("reset");

      // IFU fetch: exact latency, cycle 0 accept -> resp pulse at cycle 3.
      cfg_stall = 0; cfg_lat = 1;
      offer("ifu_lat", 1, 0, 32'h8000_0000, 0, 0, 0, 0, 1, 1);
      @(negedge clk); ifu_req_valid = 0;
      check_mem("ifu_lat_c1", 0, 32'h8000_0000, 0, 0, 0);
      @(negedge clk);
      check("ifu_lat_c2_mreq", 64'(mem_req_valid), 64'(0));
      check("ifu_lat_c2_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      @(negedge clk);
      check("ifu_lat_c3_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(2'b10));
      @(negedge clk);
      check("ifu_lat_c4_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      check("ifu_lat_c4_hold", 64'(ifu_rdata), 64'(32'h0010_0093));
      wait_drain("ifu_lat", 10);

      // Arbitration vector table.
      for (int i = 0; i < 8; i++) begin
         cfg_stall = vt[i].stall; cfg_lat = vt[i].lat;
         w_exp = vt[i].exp_w;
`ifdef ARB_ROUND_ROBIN_EN
         if (vt[i].iv && vt[i].lv) w_exp = pick(1'b1, 1'b1);
`endif
         offer($sformatf("vec%0d", i), vt[i].iv, vt[i].lv, vt[i].ia, vt[i].la,
               vt[i].wen, vt[i].wd, vt[i].wm, w_exp, 1);
         @(negedge clk); ifu_req_valid = 0; lsu_req_valid = 0;
         if (w_exp != 0) begin
            check_mem($sformatf("vec%0d", i), w_exp == 2, (w_exp == 2) ? vt[i].la : vt[i].ia,
                      vt[i].wen, vt[i].wd, vt[i].wm);
            wait_drain($sformatf("vec%0d", i), 40);
         end
      end

      // Both valid after reset: LSU first, waiting IFU granted at cycle 3.
      do_reset();
      cfg_stall = 0; cfg_lat = 1;
      offer("tie", 1, 1, 32'h8000_0030, 32'h8000_0100, 0, 0, 0, 2, 1);
      @(negedge clk); lsu_req_valid = 0; #1;
      check("tie_c1_ifu_ready", 64'(ifu_req_ready), 64'(0));
      check_mem("tie_c1", 1, 32'h8000_0100, 0, 0, 0);
      @(negedge clk); #1;
      check("tie_c2_ifu_ready", 64'(ifu_req_ready), 64'(0));
      @(negedge clk);
      offer("tie_c3", 1, 0, 32'h8000_0030, 0, 0, 0, 0, 1, 1);
      @(negedge clk); ifu_req_valid = 0;
      wait_drain("tie", 20);

      // Both continuously valid for four transactions.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         offer($sformatf("cont%0d", k), 1, 1, 32'h8000_0040 + 32'(k), 32'h8000_0140 + 32'(k),
               0, 0, 0, rr_seq[k], 1);
         @(negedge clk);
         @(negedge clk);
         @(negedge clk);
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      wait_drain("cont", 20);

      // Store with memory stalling three cycles: request held stable.
      cfg_stall = 3; cfg_lat = 1;
      offer("stall", 0, 1, 0, 32'h8000_0200, 1, 32'hDEAD_BEEF, 4'hF, 2, 1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); lsu_req_valid = 0;
         check_mem($sformatf("stall_c%0d", c), 1, 32'h8000_0200, 1, 32'hDEAD_BEEF, 4'hF);
      end
      @(negedge clk);
      check("stall_c5_mreq", 64'(mem_req_valid), 64'(0));
      wait_drain("stall", 20);

      // Reset in RESP before the response; the late response must be dropped.
      cfg_stall = 0; cfg_lat = 4;
      offer("rstresp", 0, 1, 0, 32'h8000_0300, 0, 0, 0, 2, 0);
      @(negedge clk); lsu_req_valid = 0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; model_last_lsu = 1'b0;
      check_outputs_zero("rstresp");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("rstresp_quiet%0d", c), 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      end

      // Spurious memory response while idle.
      cfg_lat = 1;
      spurious = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("spur_quiet%0d", c), 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      end
      offer("spur_after", 1, 0, 32'h8000_0008, 0, 0, 0, 0, 1, 1);
      @(negedge clk); ifu_req_valid = 0;
      check_mem("spur_after", 0, 32'h8000_0008, 0, 0, 0);
      wait_drain("spur_after", 20);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
